id_ex_stage_reg: RTL and testbench
==================================

// Module: id_ex_stage_reg
// PURPOSE
//  ID/EX pipeline register of the pipelined LEGv8 core. It sits directly downstream of the
//  decode-stage control unit and register file, and latches their control bits, operands and
//  register fields for the EX stage.
//  It also contains load-use hazard detection. On a load-use hazard it inserts a bubble and
//  requests that PC and IF/ID hold. A branch flush from MEM also squashes the entry.
//  A saturating counter records the number of hazard bubbles, for performance debug.
// PARAMETERS
//  DATA_W  64  width of PC, register operands and sign-extended immediate
//  REG_AW  5   register index width
//  CNT_W   16  width of the hazard-bubble counter
// PORTS
//  clk           in   1       rising-edge clock
//  rst           in   1       asynchronous, active-high reset
//  flush_i       in   1       branch taken in MEM; squash the instruction entering EX
//  id_valid      in   1       IF/ID holds a real instruction
//  id_pc         in   DATA_W  PC of the decode instruction
//  id_rd1        in   DATA_W  register-file read data 1
//  id_rd2        in   DATA_W  register-file read data 2
//  id_imm        in   DATA_W  sign-extended immediate
//  id_rn         in   REG_AW  source register index, Rn
//  id_rm         in   REG_AW  source register index, Rm/Rt
//  id_rd         in   REG_AW  destination register index
//  id_opcode     in   11      instr[31:21]; consumed by the EX ALU-control decoder
//  id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch
//                in   1 each  decode control bits
//  id_aluop      in   2       decode ALUOp
//  ex_*          out  same    registered copies of every id_* field above, including ex_valid
//  hazard_stall  out  1       combinational; PC and IF/ID must hold this cycle
//  stall_cnt     out  CNT_W   count of hazard bubbles inserted
// BEHAVIOUR
//  - Reset (async, immediate): every ex_* output = 0, including ex_valid and all control bits.
//    stall_cnt = 0. hazard_stall then evaluates to 0 because ex_valid = 0.
//  - hazard_stall = ~flush_i & ex_valid & ex_memread & id_valid & (ex_rd != 31)
//    & ((ex_rd == id_rn) | (ex_rd == id_rm)).
//    Register 31 is XZR and never causes a hazard.
//  - Latency is 1 cycle. Each posedge applies the first matching case below:
//    1) flush_i = 1: the six control bits, ex_aluop and ex_valid load 0.
//       Data and index fields capture the id_* inputs as normal.
//    2) hazard_stall = 1: bubble, with the same loading as case 1. stall_cnt += 1.
//       The stalled instruction stays in IF/ID, because upstream honours hazard_stall,
//       and enters EX on the next non-hazard cycle.
//    3) otherwise: every ex_* field loads its id_* input; ex_valid = id_valid.
//  - If id_valid = 0 in case 3, the control bits are still captured as presented.
//    Downstream stages must qualify their actions with ex_valid.
//  - stall_cnt saturates at all-ones and never wraps. Flush bubbles are not counted.
//  - If flush_i and a hazard condition occur in the same cycle, the flush wins:
//    hazard_stall = 0 and stall_cnt is unchanged.
//  - Reset asserted mid-stall clears the stall on the same cycle (async).
//    The first post-reset edge loads case 3.
//  - The block has no internal FSM beyond the pipeline register and the counter.
//    Only one bubble is inserted per load-use pair. After the bubble, ex_memread = 0,
//    so the hazard clears by construction.
// TESTING
//  1. Reset during normal flow, with ex_* nonzero and rst pulsed mid-cycle
//     -> all ex_* = 0 and stall_cnt = 0 before the next edge.
//  2. LDUR: id_opcode = 11'b11111000010, ctrl = 1,1,1,1,0,0, aluop = 00, id_rd = 3
//     -> next cycle ex_* match the inputs exactly, ex_valid = 1.
//  3. LDUR X3 in EX, ADD X4,X3,X5 in ID (id_rn = 3)
//     -> hazard_stall = 1 and the next EX is a bubble: control 0, ex_valid 0, stall_cnt = 1.
//     On the following edge the ADD reaches EX with ex_rd = 4 and hazard_stall = 0.
//  4. LDUR XZR in EX (ex_rd = 31) with id_rn = 31 -> hazard_stall = 0 and no bubble.
//  5. Hazard condition with flush_i = 1 in the same cycle
//     -> hazard_stall = 0, EX bubble, stall_cnt unchanged.
//  6. CNT_W = 2 with 5 back-to-back load-use pairs -> stall_cnt goes 1, 2, 3, 3, 3 (saturates).

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register for the pipelined LEGv8 core, with load-use hazard
// detection, flush squashing and a saturating hazard-bubble counter.
module id_ex_stage_reg #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rn,
    input  logic [REG_AW-1:0] id_rm,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [10:0]       id_opcode,
    input  logic              id_alusrc,
    input  logic              id_memtoreg,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_branch,
    input  logic [1:0]        id_aluop,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rn,
    output logic [REG_AW-1:0] ex_rm,
    output logic [REG_AW-1:0] ex_rd,
    output logic [10:0]       ex_opcode,
    output logic              ex_alusrc,
    output logic              ex_memtoreg,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_branch,
    output logic [1:0]        ex_aluop,
    output logic              hazard_stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [REG_AW-1:0] XZR = REG_AW'(31);

    logic rd_match;
    logic bubble;

    // Load-use hazard: a load in EX whose destination feeds the instruction in ID.
    assign rd_match     = (ex_rd == id_rn) || (ex_rd == id_rm);
    assign hazard_stall = !flush_i && ex_valid && ex_memread && id_valid
                          && (ex_rd != XZR) && rd_match;
    assign bubble       = flush_i || hazard_stall;

    // Data and register-index fields always follow ID; only control is squashed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_pc     <= '0;
            ex_rd1    <= '0;
            ex_rd2    <= '0;
            ex_imm    <= '0;
            ex_rn     <= '0;
            ex_rm     <= '0;
            ex_rd     <= '0;
            ex_opcode <= '0;
        end else begin
            ex_pc     <= id_pc;
            ex_rd1    <= id_rd1;
            ex_rd2    <= id_rd2;
            ex_imm    <= id_imm;
            ex_rn     <= id_rn;
            ex_rm     <= id_rm;
            ex_rd     <= id_rd;
            ex_opcode <= id_opcode;
        end
    end

    // Control bits and valid: zeroed on flush or hazard bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_branch   <= 1'b0;
            ex_aluop    <= 2'b00;
        end else if (bubble) begin
            ex_valid    <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_branch   <= 1'b0;
            ex_aluop    <= 2'b00;
        end else begin
            ex_valid    <= id_valid;
            ex_alusrc   <= id_alusrc;
            ex_memtoreg <= id_memtoreg;
            ex_regwrite <= id_regwrite;
            ex_memread  <= id_memread;
            ex_memwrite <= id_memwrite;
            ex_branch   <= id_branch;
            ex_aluop    <= id_aluop;
        end
    end

    // Hazard-bubble counter, saturating; flush bubbles are excluded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (hazard_stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: pass-through, load-use bubbles, XZR,
// flush priority, async reset and counter saturation (narrow-counter instance).
module tb_id_ex_stage_reg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned REG_AW = 5;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush_i;
    logic              id_valid;
    logic [DATA_W-1:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [REG_AW-1:0] id_rn, id_rm, id_rd;
    logic [10:0]       id_opcode;
    logic              id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch;
    logic [1:0]        id_aluop;

    logic              ex_valid;
    logic [DATA_W-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [REG_AW-1:0] ex_rn, ex_rm, ex_rd;
    logic [10:0]       ex_opcode;
    logic              ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch;
    logic [1:0]        ex_aluop;
    logic              hazard_stall;
    logic [15:0]       stall_cnt;

    logic              s_valid;
    logic [DATA_W-1:0] s_pc, s_rd1, s_rd2, s_imm;
    logic [REG_AW-1:0] s_rn, s_rm, s_rd;
    logic [10:0]       s_opcode;
    logic              s_alusrc, s_memtoreg, s_regwrite, s_memread, s_memwrite, s_branch;
    logic [1:0]        s_aluop;
    logic              s_hazard;
    logic [1:0]        s_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .id_valid(id_valid),
        .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd), .id_opcode(id_opcode),
        .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_branch(id_branch),
        .id_aluop(id_aluop),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd), .ex_opcode(ex_opcode),
        .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
        .ex_aluop(ex_aluop), .hazard_stall(hazard_stall), .stall_cnt(stall_cnt)
    );

    // Narrow-counter instance on the same stimulus, for saturation checks.
    id_ex_stage_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .flush_i(flush_i), .id_valid(id_valid),
        .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd), .id_opcode(id_opcode),
        .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_branch(id_branch),
        .id_aluop(id_aluop),
        .ex_valid(s_valid), .ex_pc(s_pc), .ex_rd1(s_rd1), .ex_rd2(s_rd2), .ex_imm(s_imm),
        .ex_rn(s_rn), .ex_rm(s_rm), .ex_rd(s_rd), .ex_opcode(s_opcode),
        .ex_alusrc(s_alusrc), .ex_memtoreg(s_memtoreg), .ex_regwrite(s_regwrite),
        .ex_memread(s_memread), .ex_memwrite(s_memwrite), .ex_branch(s_branch),
        .ex_aluop(s_aluop), .hazard_stall(s_hazard), .stall_cnt(s_cnt)
    );

    wire [5:0] ex_ctrl = {ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic [10:0] op,
                         input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                         input logic [5:0] ctrl, input logic [1:0] aluop);
        id_valid  = v;
        id_pc     = pc;
        id_rd1    = pc ^ 64'hA5A5_0000_1111_2222;
        id_rd2    = pc + 64'h100;
        id_imm    = {60'h0, rd[3:0]} | 64'hFFFF_0000_0000_0000;
        id_opcode = op;
        id_rn     = rn;
        id_rm     = rm;
        id_rd     = rd;
        {id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch} = ctrl;
        id_aluop  = aluop;
    endtask

    task automatic ldur(input logic [4:0] rd, input logic [63:0] pc);
        drive(1'b1, pc, OP_LDUR, 5'd1, 5'd0, rd, 6'b111100, 2'b00);
    endtask

    task automatic add(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                       input logic [63:0] pc);
        drive(1'b1, pc, OP_ADD, rn, rm, rd, 6'b001000, 2'b10);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        flush_i = 1'b0;
        drive(1'b0, 64'h0, 11'h0, 5'd0, 5'd0, 5'd0, 6'b0, 2'b0);
        #3;
        check("reset_valid", 64'(ex_valid), 64'd0);
        check("reset_ctrl", 64'(ex_ctrl), 64'd0);
        check("reset_cnt", 64'(stall_cnt), 64'd0);
        check("reset_hazard", 64'(hazard_stall), 64'd0);
        #9 rst = 1'b0;

        // LDUR X3 passes straight through
        ldur(5'd3, 64'h1000);
        tick();
        check("ldur_valid", 64'(ex_valid), 64'd1);
        check("ldur_pc", ex_pc, 64'h1000);
        check("ldur_rd1", ex_rd1, 64'h1000 ^ 64'hA5A5_0000_1111_2222);
        check("ldur_rd2", ex_rd2, 64'h1100);
        check("ldur_imm", ex_imm, 64'hFFFF_0000_0000_0003);
        check("ldur_op", 64'(ex_opcode), 64'(OP_LDUR));
        check("ldur_regs", 64'({ex_rn, ex_rm, ex_rd}), 64'({5'd1, 5'd0, 5'd3}));
        check("ldur_ctrl", 64'(ex_ctrl), 64'b111100);
        check("ldur_aluop", 64'(ex_aluop), 64'd0);

        // ADD X4,X3,X5 behind the load: one bubble, then ADD enters EX
        add(5'd4, 5'd3, 5'd5, 64'h1004);
        #1;
        check("lu_hazard", 64'(hazard_stall), 64'd1);
        tick();
        check("lu_bubble_valid", 64'(ex_valid), 64'd0);
        check("lu_bubble_ctrl", 64'({ex_ctrl, ex_aluop}), 64'd0);
        check("lu_cnt", 64'(stall_cnt), 64'd1);
        check("lu_hazard_clear", 64'(hazard_stall), 64'd0);
        tick();
        check("lu_add_rd", 64'(ex_rd), 64'd4);
        check("lu_add_ctrl", 64'({ex_valid, ex_ctrl, ex_aluop}), 64'b1_001000_10);
        check("lu_cnt_hold", 64'(stall_cnt), 64'd1);

        // Hazard via Rm
        ldur(5'd7, 64'h1008);
        tick();
        add(5'd8, 5'd2, 5'd7, 64'h100C);
        #1;
        check("rm_hazard", 64'(hazard_stall), 64'd1);
        tick();
        check("rm_cnt", 64'(stall_cnt), 64'd2);
        tick();

        // Load to XZR never stalls
        ldur(5'd31, 64'h1010);
        tick();
        add(5'd4, 5'd31, 5'd31, 64'h1014);
        #1;
        check("xzr_hazard", 64'(hazard_stall), 64'd0);
        tick();
        check("xzr_valid", 64'(ex_valid), 64'd1);
        check("xzr_cnt", 64'(stall_cnt), 64'd2);

        // Invalid ID slot: no hazard, control captured, ex_valid low
        ldur(5'd3, 64'h1018);
        tick();
        drive(1'b0, 64'h101C, OP_ADD, 5'd3, 5'd3, 5'd9, 6'b001000, 2'b10);
        #1;
        check("inval_hazard", 64'(hazard_stall), 64'd0);
        tick();
        check("inval_ex", 64'({ex_valid, ex_ctrl, ex_aluop}), 64'b0_001000_10);

        // Flush beats hazard
        ldur(5'd3, 64'h1020);
        tick();
        add(5'd4, 5'd3, 5'd5, 64'h1024);
        flush_i = 1'b1;
        #1;
        check("flush_hazard", 64'(hazard_stall), 64'd0);
        tick();
        flush_i = 1'b0;
        check("flush_bubble", 64'({ex_valid, ex_ctrl, ex_aluop}), 64'd0);
        check("flush_rd", 64'(ex_rd), 64'd4);
        check("flush_cnt", 64'(stall_cnt), 64'd2);

        // Async reset mid-stall
        ldur(5'd6, 64'h1030);
        tick();
        add(5'd4, 5'd6, 5'd1, 64'h1034);
        #1;
        check("pre_rst_hazard", 64'(hazard_stall), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_hazard", 64'(hazard_stall), 64'd0);
        check("mid_rst_ex", 64'({ex_valid, ex_ctrl, ex_aluop}), 64'd0);
        check("mid_rst_pc", ex_pc, 64'd0);
        check("mid_rst_rd", 64'(ex_rd), 64'd0);
        check("mid_rst_cnt", 64'(stall_cnt), 64'd0);
        rst = 1'b0;
        tick();
        check("post_rst_rd", 64'(ex_rd), 64'd4);
        check("post_rst_valid", 64'(ex_valid), 64'd1);

        // Five load-use pairs from zero: narrow counter saturates at 3
        rst = 1'b1;
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ldur(5'd10, 64'h2000 + 64'(i * 8));
            tick();
            add(5'd11, 5'd10, 5'd12, 64'h2004 + 64'(i * 8));
            tick();
            check($sformatf("sat_cnt_%0d", i), 64'(s_cnt), 64'((i < 3) ? i + 1 : 3));
            check($sformatf("wide_cnt_%0d", i), 64'(stall_cnt), 64'(i + 1));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
